// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Runtime-programmable clock divider for the sensor/sampling timebase.
// Produces a 50%-duty divided clock (clk_out) from clk_in, with a half-period
// of half_q clk_in cycles. New half-periods arrive over a valid/ready
// handshake. While the divider runs, a new value is held as pending and is
// applied only on a falling toggle of clk_out, so clk_out never glitches.
// Start/stop sequencing ensures clk_out always halts low after a complete
// high phase.
//
// Optional build macro:
//   CLK_DIV_CTRL_CFG_CHECK_EN
//     Defined   : a zero half-period is consumed, discarded, and flagged on
//                 cfg_err (a one-cycle pulse).
//     Undefined : a zero half-period is clamped to 1, and cfg_err is tied low.
//
// Parameters:
//   CNT_WIDTH    - width of the half-period value and of the counter
//   DEFAULT_HALF - half-period loaded at reset (1 .. 2^CNT_WIDTH-1)
//
// Ports:
//   clk_in    in   clock
//   rst_n     in   asynchronous active-low reset
//   en        in   run request (level)
//   cfg_valid in   new half-period offered
//   cfg_half  in   offered half-period, in clk_in cycles
//   cfg_ready out  controller can accept a config
//   cfg_err   out  one-cycle pulse when a zero config is rejected
//   clk_out   out  divided clock (registered)
//   tick      out  one-cycle pulse with each 0->1 transition of clk_out
//   running   out  high in RUN and DRAIN
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int          CNT_WIDTH    = 16,
    parameter int unsigned DEFAULT_HALF = 50
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_valid,
    input  logic [CNT_WIDTH-1:0] cfg_half,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 running
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] HALF_RESET = CNT_WIDTH'(DEFAULT_HALF);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Maps an offered half-period onto the value to store (zero -> 1 clamp).
    function automatic logic [CNT_WIDTH-1:0] clamp_half(input logic [CNT_WIDTH-1:0] val);
        logic [CNT_WIDTH-1:0] res;
        if (val == CNT_ZERO) begin
            res = CNT_ONE;
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_t               state_q,   state_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [CNT_WIDTH-1:0] half_q,    half_d;
    logic [CNT_WIDTH-1:0] pend_q,    pend_d;
    logic                 pend_v_q,  pend_v_d;
    logic                 clk_out_q, clk_out_d;
    logic                 tick_q,    tick_d;
    logic                 err_q,     err_d;
    logic                 ready_q,   ready_d;
    logic                 run_q,     run_d;

    logic                 xfer_s;
    logic                 acc_s;
    logic [CNT_WIDTH-1:0] cfg_val_s;
    logic                 term_s;

    // Handshake qualification and config value sanitising.
    always_comb begin
        xfer_s = cfg_valid & ready_q;
`ifdef CLK_DIV_CTRL_CFG_CHECK_EN
        acc_s     = xfer_s & (cfg_half != CNT_ZERO);
        cfg_val_s = cfg_half;
        err_d     = xfer_s & (cfg_half == CNT_ZERO);
`else
        acc_s     = xfer_s;
        cfg_val_s = clamp_half(cfg_half);
        err_d     = 1'b0;
`endif
        // Counter never exceeds half_q-1, so this is the end-of-phase compare.
        term_s = (cnt_q == (half_q - CNT_ONE));
    end

    // Next-state logic for the divider FSM, counter and config path.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        case (state_q)
            ST_STOP: begin
                cnt_d     = CNT_ZERO;
                clk_out_d = 1'b0;
                // Written directly so a start on the same edge uses it.
                if (acc_s) begin
                    half_d = cfg_val_s;
                end else begin
                    half_d = half_q;
                end
                if (en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STOP;
                end
            end

            ST_RUN: begin
                if (acc_s) begin
                    pend_d   = cfg_val_s;
                    pend_v_d = 1'b1;
                end else begin
                    pend_d   = pend_q;
                end
                if (!en && !clk_out_q) begin
                    // Low phase: stop at once.
                    state_d   = ST_STOP;
                    cnt_d     = CNT_ZERO;
                    clk_out_d = 1'b0;
                end else if (term_s) begin
                    cnt_d     = CNT_ZERO;
                    clk_out_d = ~clk_out_q;
                    if (!clk_out_q) begin
                        tick_d = 1'b1;
                    end else if (pend_v_q) begin
                        // Falling toggle: old pending moves in. A config
                        // accepted on this edge cannot coexist with it
                        // (ready was low), so it stays pending.
                        half_d   = pend_q;
                        pend_v_d = 1'b0;
                    end else begin
                        half_d = half_q;
                    end
                    if (!en && clk_out_q) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!en) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_DRAIN: begin
                if (acc_s) begin
                    pend_d   = cfg_val_s;
                    pend_v_d = 1'b1;
                end else begin
                    pend_d   = pend_q;
                end
                if (term_s) begin
                    cnt_d     = CNT_ZERO;
                    clk_out_d = 1'b0;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d   = ST_STOP;
                cnt_d     = CNT_ZERO;
                clk_out_d = 1'b0;
                pend_v_d  = 1'b0;
            end
        endcase

        // Anything still pending when entering STOP is applied on that edge,
        // so STOP never holds a stale config with ready low.
        if (state_d == ST_STOP) begin
            if (pend_v_d) begin
                half_d = pend_d;
            end else begin
                half_d = half_d;
            end
            pend_v_d = 1'b0;
        end else begin
            pend_v_d = pend_v_d;
        end

        ready_d = ~pend_v_d;
        run_d   = (state_d != ST_STOP);
    end

    // State and registered-output flops.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STOP;
            cnt_q     <= CNT_ZERO;
            half_q    <= HALF_RESET;
            pend_q    <= CNT_ZERO;
            pend_v_q  <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            run_q     <= run_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign cfg_err   = err_q;
    assign cfg_ready = ready_q;
    assign running   = run_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

    logic        clk_in;
    logic        rst_n;
    logic        en;
    logic        cfg_valid;
    logic [15:0] cfg_half;
    logic        cfg_ready;
    logic        cfg_err;
    logic        clk_out;
    logic        tick;
    logic        running;

    int n_checks;
    int n_pass;
    int n;
    int nt;
    int n2;
    int nt2;

    clk_div_ctrl #(.CNT_WIDTH(16), .DEFAULT_HALF(50)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_in);
    endtask

    // Counts negedges until clk_out reaches lvl; n = -1 on timeout.
    task automatic wait_level(input logic lvl, output int cnt, output int ticks);
        cnt   = 0;
        ticks = 0;
        while (clk_out !== lvl && cnt < 300) begin
            cyc();
            cnt++;
            if (tick === 1'b1) ticks++;
        end
        if (clk_out !== lvl) cnt = -1;
    endtask

    // Offers a config for one cycle, optionally with en raised together.
    task automatic send_cfg(input logic [15:0] val, input logic en_v);
        cfg_valid = 1'b1;
        cfg_half  = val;
        en        = en_v;
        cyc();
        cfg_valid = 1'b0;
        cfg_half  = 16'd0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 16'd0;
        cyc();
        cyc();
        check_eq("rst_clk_out", clk_out, 0);
        check_eq("rst_tick", tick, 0);
        check_eq("rst_cfg_err", cfg_err, 0);
        check_eq("rst_cfg_ready", cfg_ready, 1);
        check_eq("rst_running", running, 0);
        rst_n = 1'b1;
        cyc();

        // Default half-period 50.
        en = 1'b1;
        cyc();
        check_eq("def_running", running, 1);
        wait_level(1'b1, n, nt);
        check_eq("def_rise", n, 50);
        check_eq("def_tick_at_rise", tick, 1);
        wait_level(1'b0, n, nt);
        check_eq("def_high", n, 50);
        wait_level(1'b1, n2, nt2);
        check_eq("def_low", n2, 50);
        check_eq("def_ticks_per_period", nt + nt2, 1);
        wait_level(1'b0, n, nt);

        // Drop en in a low phase: STOP on the next edge.
        en = 1'b0;
        cyc();
        check_eq("lowstop_running", running, 0);
        check_eq("lowstop_clk_out", clk_out, 0);

        // Config in STOP, then start.
        send_cfg(16'd3, 1'b0);
        check_eq("stopcfg_ready", cfg_ready, 1);
        en = 1'b1;
        cyc();
        wait_level(1'b1, n, nt);
        check_eq("h3_rise", n, 3);
        wait_level(1'b0, n, nt);
        check_eq("h3_high", n, 3);
        wait_level(1'b1, n, nt);
        check_eq("h3_low", n, 3);
        wait_level(1'b0, n, nt);
        en = 1'b0;
        cyc();

        // Config with start on the same edge; drain after a rising edge.
        send_cfg(16'd5, 1'b1);
        wait_level(1'b1, n, nt);
        check_eq("h5_rise", n, 5);
        en = 1'b0;
        cyc();
        check_eq("drain_running", running, 1);
        check_eq("drain_clk_out", clk_out, 1);
        wait_level(1'b0, n, nt);
        check_eq("drain_rest_high", n, 4);
        check_eq("drain_stop_running", running, 0);

        // Mid-high-phase config change with H=4 -> 2.
        send_cfg(16'd4, 1'b1);
        wait_level(1'b1, n, nt);
        check_eq("h4_rise", n, 4);
        cyc();
        send_cfg(16'd2, 1'b1);
        check_eq("pend_ready_low", cfg_ready, 0);
        wait_level(1'b0, n, nt);
        check_eq("pend_high_rest", n, 2);
        check_eq("pend_ready_back", cfg_ready, 1);
        wait_level(1'b1, n, nt);
        check_eq("pend_new_low", n, 2);
        wait_level(1'b0, n, nt);
        check_eq("pend_new_high", n, 2);

        // Zero config.
        en = 1'b0;
        cyc();
        check_eq("zero_pre_running", running, 0);
        send_cfg(16'd0, 1'b1);
`ifdef CLK_DIV_CTRL_CFG_CHECK_EN
        check_eq("zero_err", cfg_err, 1);
        wait_level(1'b1, n, nt);
        check_eq("zero_rise", n, 2);
        wait_level(1'b0, n, nt);
        check_eq("zero_high", n, 2);
`else
        check_eq("zero_err", cfg_err, 0);
        wait_level(1'b1, n, nt);
        check_eq("zero_rise", n, 1);
        wait_level(1'b0, n, nt);
        check_eq("zero_high", n, 1);
`endif

        // Async reset mid-high-phase with a pending config.
        en = 1'b0;
        cyc();
        send_cfg(16'd6, 1'b1);
        wait_level(1'b1, n, nt);
        check_eq("h6_rise", n, 6);
        send_cfg(16'd9, 1'b1);
        check_eq("h6_pend_ready", cfg_ready, 0);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_clk_out", clk_out, 0);
        check_eq("arst_tick", tick, 0);
        check_eq("arst_running", running, 0);
        check_eq("arst_ready", cfg_ready, 1);
        check_eq("arst_err", cfg_err, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        wait_level(1'b1, n, nt);
        check_eq("post_rst_rise", n, 50);
        wait_level(1'b0, n, nt);
        check_eq("post_rst_high", n, 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
